// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, sizes and helpers for the message scheduler.
package sha1_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      SCHED_LOAD  = 2'd0,
      SCHED_START = 2'd1,
      SCHED_ROUND = 2'd2
   } sched_state_e;

   localparam int SHA1_ROUNDS    = 80;
   localparam int SHA1_BLK_WORDS = 16;

   function automatic word_t rotl1(input word_t x);
      return {x[30:0], x[31]};
   endfunction

   function automatic word_t bswap32(input word_t x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/sha1_w_window.sv
// 16-entry schedule window: indexed writes while a block loads, shift-down
// with new word entering at the top while rounds run.
module sha1_w_window
   import sha1_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en_i,
   input  logic [3:0] wr_idx_i,
   input  word_t      wr_data_i,
   input  logic       shift_en_i,
   input  word_t      shift_data_i,
   output word_t      tap0_o,
   output word_t      tap2_o,
   output word_t      tap8_o,
   output word_t      tap13_o
);

   word_t win_q [SHA1_BLK_WORDS];
   word_t win_d [SHA1_BLK_WORDS];

   // Shift and indexed write never coincide: one is LOAD-only, the other ROUND-only.
   always_comb begin
      win_d = win_q;
      if (shift_en_i) begin
         for (int i = 0; i < SHA1_BLK_WORDS - 1; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[SHA1_BLK_WORDS-1] = shift_data_i;
      end else if (wr_en_i) begin
         win_d[wr_idx_i] = wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SHA1_BLK_WORDS; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         win_q <= win_d;
      end
   end

   assign tap0_o  = win_q[0];
   assign tap2_o  = win_q[2];
   assign tap8_o  = win_q[8];
   assign tap13_o = win_q[13];

endmodule

// File: rtl/sha1_msg_sched.sv
// SHA-1 message scheduler: loads a 16-word block, pulses start, then supplies
// W[t] to the round controller. SHA1_SCHED_BSWAP_EN byte-swaps host words.
module sha1_msg_sched
   import sha1_pkg::*;
#(
   parameter int ROUNDS = SHA1_ROUNDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        start,
   input  logic        round_en,
   input  logic [7:0]  t_i,
   input  logic        done_i,
   output logic [31:0] w_o,
   output logic        w_valid,
   output logic        busy
);

   localparam int          WORDS    = SHA1_BLK_WORDS;
   localparam logic [31:0] ROUNDS_W = ROUNDS;
   localparam logic [31:0] WORDS_W  = WORDS;

   sched_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         accept;
   logic         in_round;
   logic [31:0]  t_ext;
   word_t        wr_word;
   word_t        w_next;
   word_t        tap0, tap2, tap8, tap13;

   assign t_ext = {24'd0, t_i};

`ifdef SHA1_SCHED_BSWAP_EN
   assign wr_word = bswap32(in_data);
`else
   assign wr_word = in_data;
`endif

   // Handshake: a word moves when in_valid && in_ready at the rising edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_ready = 1'b0;
      busy     = 1'b1;
      accept   = 1'b0;
      case (state_q)
         SCHED_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept = 1'b1;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_d = SCHED_START;
            end
         end
         SCHED_START: state_d = SCHED_ROUND;
         SCHED_ROUND: if (done_i) state_d = SCHED_LOAD;
         default:     state_d = SCHED_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCHED_LOAD;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign start    = (state_q == SCHED_START);
   assign in_round = (state_q == SCHED_ROUND) && round_en && (t_ext < ROUNDS_W);
   assign w_next   = (t_ext < WORDS_W) ? tap0 : rotl1(tap13 ^ tap8 ^ tap2 ^ tap0);
   assign w_valid  = in_round;
   assign w_o      = in_round ? w_next : '0;

   sha1_w_window u_window (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (accept),
      .wr_idx_i     (cnt_q),
      .wr_data_i    (wr_word),
      .shift_en_i   (in_round),
      .shift_data_i (w_next),
      .tap0_o       (tap0),
      .tap2_o       (tap2),
      .tap8_o       (tap8),
      .tap13_o      (tap13)
   );

endmodule
